boolfunc_dec_pipe: RTL and testbench

// - Programmable N-input, M-output Boolean function unit; decoder-based successor of the fixed 3-input POS block.
// - Each output has a runtime mask of 2^N_IN minterms/maxterms and an SOP/POS mode bit.
// - Input vectors flow through a 2-stage valid/ready pipeline: decode, then evaluate.
// - Sits between a vector source and a consumer; functions are rewritten over a config write port.

---
 rtl/boolfunc_dec_pipe.sv | 125 ++++++++++++
 tb/tb_boolfunc_dec_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boolfunc_dec_pipe.sv
// Programmable N_IN-input / N_OUT-output Boolean function unit: one-hot decode stage, then mask/mode evaluate stage.
// Define BOOLFUNC_SHADOW_EN to stage config writes in shadow registers until cfg_commit.
module boolfunc_dec_pipe #(
    parameter  int N_IN  = 3,
    parameter  int N_OUT = 2,
    localparam int T     = 2 ** N_IN,
    localparam int SW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_sel,
    input  logic             cfg_mode,
    input  logic [T-1:0]     cfg_mask,
    input  logic             cfg_commit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_f
);

    logic             s1_valid;
    logic             s2_ready;
    logic [T-1:0]     dec_d;
    logic [T-1:0]     dec_q;
    logic [N_OUT-1:0] mode_q;
    logic [N_OUT-1:0] eval_f;
    logic [T-1:0]     mask_q [N_OUT];

    assign s2_ready = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_ready;

    always_comb begin
        dec_d = '0;
        for (int unsigned i = 0; i < T; i++)
            dec_d[i] = (32'(in_vec) == i);
    end

    // POS is the complement of the SOP hit over the same term list.
    always_comb begin
        eval_f = '0;
        for (int unsigned k = 0; k < N_OUT; k++)
            eval_f[k] = mode_q[k] ^ (|(dec_q & mask_q[k]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            dec_q    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid)
                dec_q <= dec_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_f     <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid)
                out_f <= eval_f;
        end
    end

`ifdef BOOLFUNC_SHADOW_EN
    logic [N_OUT-1:0] sh_mode_q;
    logic [N_OUT-1:0] sh_mode_d;
    logic [T-1:0]     sh_mask_q [N_OUT];
    logic [T-1:0]     sh_mask_d [N_OUT];

    // Commit copies the post-write shadow view so a same-cycle write is included.
    always_comb begin
        sh_mode_d = sh_mode_q;
        sh_mask_d = sh_mask_q;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (cfg_we && (32'(cfg_sel) == k)) begin
                sh_mode_d[k] = cfg_mode;
                sh_mask_d[k] = cfg_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_mode_q <= '0;
            mode_q    <= '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                sh_mask_q[k] <= '0;
                mask_q[k]    <= '0;
            end
        end else begin
            sh_mode_q <= sh_mode_d;
            sh_mask_q <= sh_mask_d;
            if (cfg_commit) begin
                mode_q <= sh_mode_d;
                mask_q <= sh_mask_d;
            end
        end
    end
`else
    logic unused_commit;
    assign unused_commit = cfg_commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= '0;
            for (int unsigned k = 0; k < N_OUT; k++)
                mask_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (cfg_we && (32'(cfg_sel) == k)) begin
                    mode_q[k] <= cfg_mode;
                    mask_q[k] <= cfg_mask;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_boolfunc_dec_pipe.sv
// Directed bench for boolfunc_dec_pipe with an accept-time scoreboard; a second N_OUT=3 instance covers out-of-range cfg_sel.
module tb_boolfunc_dec_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_sel = '0;
    logic       cfg_mode = 1'b0;
    logic [7:0] cfg_mask = '0;
    logic       cfg_commit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_vec = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_f;

    logic       b_cfg_we = 1'b0;
    logic [1:0] b_cfg_sel = '0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic       b_out_valid;
    logic [2:0] b_out_f;

    int errors = 0;
    int checks = 0;

    logic [1:0]      exp_q [$];
    logic [1:0]      exp_e;
    logic [1:0]      m_mode = '0;
    logic [1:0][7:0] m_mask = '0;
    logic [1:0]      s_mode = '0;
    logic [1:0][7:0] s_mask = '0;
    logic [1:0]      held;

    boolfunc_dec_pipe #(.N_IN(3), .N_OUT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask), .cfg_commit(cfg_commit),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f)
    );

    boolfunc_dec_pipe #(.N_IN(3), .N_OUT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(b_cfg_we), .cfg_sel(b_cfg_sel), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask), .cfg_commit(cfg_commit),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(in_vec),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_f(b_out_f)
    );

    always #5 clk = ~clk;

    // Bit k: SOP -> mask bit at the input index; POS -> its complement.
    function automatic logic [1:0] model(input logic [2:0] v);
        logic [1:0] r;
        for (int k = 0; k < 2; k++)
            r[k] = m_mode[k] ? ~m_mask[k][v] : m_mask[k][v];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: got out_f=%0d with no expected entry", out_f);
                end
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    checks++;
                    assert (out_f === exp_e) else begin
                        errors++;
                        $error("FAIL sb_out_f: got %0d expected %0d", out_f, exp_e);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_vec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic sel, input logic mode, input logic [7:0] mask, input logic commit);
        cfg_we = 1'b1; cfg_sel = sel; cfg_mode = mode; cfg_mask = mask; cfg_commit = commit;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        s_mode[sel] = mode;
        s_mask[sel] = mask;
`ifdef BOOLFUNC_SHADOW_EN
        if (commit) begin
            m_mode = s_mode;
            m_mask = s_mask;
        end
`else
        m_mode[sel] = mode;
        m_mask[sel] = mask;
`endif
    endtask

    task automatic commit_pulse();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
`ifdef BOOLFUNC_SHADOW_EN
        m_mode = s_mode;
        m_mask = s_mask;
`endif
    endtask

    task automatic send(input logic [2:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_vec = v;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++)
            tick();
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_f", {30'b0, out_f}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // empty SOP masks read 0, empty POS masks read 1
        for (int v = 0; v < 8; v++) send(3'(v));
        drain();
        cfg_write(1'b0, 1'b1, 8'h00, 1'b1);
        cfg_write(1'b1, 1'b1, 8'h00, 1'b1);
        for (int v = 0; v < 8; v++) send(3'(v));
        drain();

        // POS M(0,3,4) and M(2,5), plus first-result latency
        cfg_write(1'b0, 1'b1, 8'b0001_1001, 1'b1);
        cfg_write(1'b1, 1'b1, 8'b0010_0100, 1'b1);
        in_valid = 1'b1; in_vec = 3'd0;
        tick();
        check("lat_cycle1", {31'b0, out_valid}, 32'd0);
        in_vec = 3'd1;
        tick();
        check("lat_cycle2", {31'b0, out_valid}, 32'd1);
        for (int v = 2; v < 8; v++) send(3'(v));
        drain();

        // SOP 8'h81 on output 0
        cfg_write(1'b0, 1'b0, 8'h81, 1'b1);
        send(3'd0); send(3'd7); send(3'd5);
        drain();

        // backpressure: two accepted, then stall with output held
        out_ready = 1'b0;
        in_valid = 1'b1; in_vec = 3'd1;
        tick();
        in_vec = 3'd2;
        tick();
        in_vec = 3'd3;
        held = model(3'd1);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_f", {30'b0, out_f}, {30'b0, held});
            check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        send(3'd3);
        send(3'd4);
        drain();

        // out-of-range select on a 3-output instance is ignored
        b_cfg_we = 1'b1; b_cfg_sel = 2'd3; cfg_mode = 1'b1; cfg_mask = 8'hFF; cfg_commit = 1'b1;
        tick();
        b_cfg_we = 1'b0; cfg_commit = 1'b0;
        b_in_valid = 1'b1; in_vec = 3'd5;
        tick();
        b_in_valid = 1'b0;
        tick();
        check("sel3_valid", {31'b0, b_out_valid}, 32'd1);
        check("sel3_out_f", {29'b0, b_out_f}, 32'd0);
        b_cfg_we = 1'b1; b_cfg_sel = 2'd2; cfg_mode = 1'b1; cfg_mask = 8'h00; cfg_commit = 1'b1;
        tick();
        b_cfg_we = 1'b0; cfg_commit = 1'b0;
        b_in_valid = 1'b1; in_vec = 3'd6;
        tick();
        b_in_valid = 1'b0;
        tick();
        check("sel2_out_f", {29'b0, b_out_f}, 32'd4);

        // mid-stream reset flushes pipeline and config
        in_valid = 1'b1; in_vec = 3'd7;
        tick();
        in_vec = 3'd0;
        tick();
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        exp_q.delete();
        m_mode = '0; m_mask = '0; s_mode = '0; s_mask = '0;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_f", {30'b0, out_f}, 32'd0);
        rst_n = 1'b1;
        tick();
        send(3'd7);
        send(3'd0);
        drain();
        check("post_rst_f", {30'b0, out_f}, 32'd0);

`ifdef BOOLFUNC_SHADOW_EN
        cfg_write(1'b0, 1'b0, 8'hFF, 1'b0);
        send(3'd3);
        drain();
        check("shadow_nocommit", {30'b0, out_f}, 32'd0);
        commit_pulse();
        send(3'd3);
        drain();
        check("shadow_commit", {30'b0, out_f}, 32'd1);
        cfg_write(1'b1, 1'b1, 8'h00, 1'b1);
        send(3'd6);
        drain();
        check("shadow_we_commit", {30'b0, out_f}, 32'd3);
`else
        commit_pulse();
        cfg_write(1'b0, 1'b0, 8'hFF, 1'b0);
        send(3'd3);
        drain();
        check("direct_write", {30'b0, out_f}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
